// File: rtl/leitor_display_7_seguimentos_pkg.sv
// Shared constants for reading back the active-low multiplexed seven-segment bus.
// Pure definitions: no logic, no latency, no flow control.
package leitor_display_pkg;

  localparam int ESTAVEL_DEF = 4;
  localparam int TIMEOUT_DEF = 65535;

  // Active-low segment codes, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_A_ALT = 7'h48;

  localparam logic [1:0] ST_AGUARDA   = 2'd0;
  localparam logic [1:0] ST_FILTRA    = 2'd1;
  localparam logic [1:0] ST_CAPTURADO = 2'd2;

  typedef enum logic [1:0] {
    AGUARDA   = ST_AGUARDA,
    FILTRA    = ST_FILTRA,
    CAPTURADO = ST_CAPTURADO
  } estado_t;

endpackage

// File: rtl/leitor_display_7_seguimentos_if.sv
// Display pins in, decoded frame out; slave side is the reader.
// Pins are free-running; outputs are a single-cycle valid pulse with no ready.
interface leitor_display_7_seguimentos_if;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] valor;
  logic        valido;
  logic        erro;
  logic        sem_sinal;

  modport master (
    output seg_n, dig_n,
    input  valor, valido, erro, sem_sinal
  );

  modport slave (
    input  seg_n, dig_n,
    output valor, valido, erro, sem_sinal
  );
endinterface

// File: rtl/leitor_display_7_seguimentos_decodificador.sv
// Combinational active-low segment pattern to hex nibble; zero latency, no flow control.
// Unknown codes give nibble 0 with o_valido low.
module decodificador_7_seguimentos_4_bits
  import leitor_display_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [3:0] o_nibble,
  output logic       o_valido
);

  always_comb begin
    o_nibble = 4'h0;
    o_valido = 1'b1;
    case (i_seg_n)
      SEG_0:            o_nibble = 4'h0;
      SEG_1:            o_nibble = 4'h1;
      SEG_2:            o_nibble = 4'h2;
      SEG_3:            o_nibble = 4'h3;
      SEG_4:            o_nibble = 4'h4;
      SEG_5:            o_nibble = 4'h5;
      SEG_6:            o_nibble = 4'h6;
      SEG_7:            o_nibble = 4'h7;
      SEG_8:            o_nibble = 4'h8;
      SEG_9:            o_nibble = 4'h9;
      SEG_A, SEG_A_ALT: o_nibble = 4'hA;
      SEG_B:            o_nibble = 4'hB;
      SEG_C:            o_nibble = 4'hC;
      SEG_D:            o_nibble = 4'hD;
      SEG_E:            o_nibble = 4'hE;
      SEG_F:            o_nibble = 4'hF;
      default:          o_valido = 1'b0;
    endcase
  end

endmodule

// File: rtl/leitor_display_7_seguimentos.sv
// Filters each scan slot of a 4-digit active-low display bus and assembles 16-bit frames.
// Pin-to-capture 2+ESTAVEL cycles, frame pulse one cycle after the 4th capture; no backpressure.
module leitor_display_7_seguimentos
  import leitor_display_pkg::*;
#(
  parameter int ESTAVEL = ESTAVEL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                            clock,
  input  logic                            resetn,
  leitor_display_7_seguimentos_if.slave   io_disp
);

  localparam logic [7:0]  EST    = 8'(ESTAVEL);
  localparam logic [7:0]  EST_M1 = 8'(ESTAVEL - 1);
  localparam logic [15:0] TMO    = 16'(TIMEOUT);

  logic [6:0]       r_seg_s1, r_seg_s2;
  logic [3:0]       r_dig_s1, r_dig_s2;
  logic [10:0]      r_par_ant;
  logic [7:0]       r_cnt;
  estado_t          r_estado;
  logic [3:0][3:0]  r_slots;
  logic [3:0]       r_mask;
  logic             r_acc;
  logic [15:0]      r_idle;
  logic [15:0]      r_valor;
  logic             r_valido;
  logic             r_erro;
  logic             r_sem;

  logic [10:0]      w_par;
  logic             w_mudou;
  logic [7:0]       w_cnt;
  logic             w_legal;
  logic [1:0]       w_idx;
  logic [3:0]       w_nib;
  logic             w_nib_ok;
  logic             w_captura;
  logic             w_grava;
  logic [3:0]       w_mask_nxt;
  logic [3:0][3:0]  w_slots_nxt;
  logic             w_acc_nxt;
  logic             w_quadro;
  logic             w_expira;
  estado_t          w_estado_nxt;

  decodificador_7_seguimentos_4_bits u_dec (
    .i_seg_n  (r_seg_s2),
    .o_nibble (w_nib),
    .o_valido (w_nib_ok)
  );

  assign w_par   = {r_dig_s2, r_seg_s2};
  assign w_mudou = (w_par != r_par_ant);
  // Count as seen in the current cycle: 0 on the first cycle of a new pair
  assign w_cnt   = w_mudou ? 8'd0 : ((r_cnt == EST) ? EST : r_cnt + 8'd1);

  always_comb begin
    w_legal = 1'b1;
    w_idx   = 2'd0;
    case (r_dig_s2)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_captura = w_legal && (w_cnt == EST_M1) && ((r_estado != CAPTURADO) || w_mudou);
  assign w_grava   = w_captura && !r_mask[w_idx];
  assign w_expira  = !w_legal && (r_idle == TMO - 16'd1);

  always_comb begin
    w_mask_nxt  = r_mask;
    w_slots_nxt = r_slots;
    w_acc_nxt   = r_acc;
    if (w_grava) begin
      w_mask_nxt[w_idx]  = 1'b1;
      w_slots_nxt[w_idx] = w_nib_ok ? w_nib : 4'h0;
      w_acc_nxt          = r_acc | !w_nib_ok;
    end
  end

  assign w_quadro = (w_mask_nxt == 4'hF);

  always_comb begin
    if (!w_legal)
      w_estado_nxt = AGUARDA;
    else if (w_captura)
      w_estado_nxt = CAPTURADO;
    else if ((r_estado == CAPTURADO) && !w_mudou)
      w_estado_nxt = CAPTURADO;
    else
      w_estado_nxt = FILTRA;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_seg_s1  <= '1;
      r_seg_s2  <= '1;
      r_dig_s1  <= '1;
      r_dig_s2  <= '1;
      r_par_ant <= '1;
      r_cnt     <= '0;
      r_estado  <= AGUARDA;
      r_slots   <= '0;
      r_mask    <= '0;
      r_acc     <= 1'b0;
      r_idle    <= '0;
      r_valor   <= '0;
      r_valido  <= 1'b0;
      r_erro    <= 1'b0;
      r_sem     <= 1'b0;
    end else begin
      r_seg_s1  <= io_disp.seg_n;
      r_seg_s2  <= r_seg_s1;
      r_dig_s1  <= io_disp.dig_n;
      r_dig_s2  <= r_dig_s1;
      r_par_ant <= w_par;
      r_cnt     <= w_cnt;
      r_estado  <= w_estado_nxt;
      r_valido  <= 1'b0;

      // Frame completion and timeout are mutually exclusive: capture needs a legal select
      if (w_quadro) begin
        r_valor  <= w_slots_nxt;
        r_erro   <= w_acc_nxt;
        r_valido <= 1'b1;
        r_slots  <= w_slots_nxt;
        r_mask   <= '0;
        r_acc    <= 1'b0;
      end else if (w_expira) begin
        r_mask   <= '0;
        r_acc    <= 1'b0;
      end else begin
        r_slots  <= w_slots_nxt;
        r_mask   <= w_mask_nxt;
        r_acc    <= w_acc_nxt;
      end

      if (w_legal) begin
        r_idle <= '0;
        r_sem  <= 1'b0;
      end else if (r_idle != TMO) begin
        r_idle <= r_idle + 16'd1;
        if (w_expira)
          r_sem <= 1'b1;
      end
    end
  end

  assign io_disp.valor     = r_valor;
  assign io_disp.valido    = r_valido;
  assign io_disp.erro      = r_erro;
  assign io_disp.sem_sinal = r_sem;

endmodule

// File: tb/tb_leitor_display_7_seguimentos.sv
// Drives display scans as timed segments; a queue-based frame model feeds a monitor that checks each pulse.
module tb_leitor_display_7_seguimentos;

  localparam int EST = 4;
  localparam int TMO = 100;

  typedef struct packed {
    logic [15:0] valor;
    logic        erro;
  } quadro_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  leitor_display_7_seguimentos_if u_if();

  leitor_display_7_seguimentos #(.ESTAVEL(EST), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .io_disp (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] fonte [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: which digits hold a value in the frame being assembled
  bit         m_got [4];
  logic [3:0] m_val [4];
  bit         m_err;
  int         m_blank;
  quadro_t    fila [$];
  logic [3:0] prev_d = 4'hF;
  logic [6:0] prev_s = 7'h7F;
  logic       prev_vld = 1'b0;

  task automatic chk(input string nome, input logic [31:0] val, input logic [31:0] esp);
    n_tests++;
    if (val !== esp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, val, esp);
    end
  endtask

  function automatic int dig_idx(input logic [3:0] d);
    for (int i = 0; i < 4; i++)
      if (d == ~(4'b0001 << i)) return i;
    return -1;
  endfunction

  function automatic logic [4:0] decodifica(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (s == fonte[i]) return {1'b1, 4'(i)};
    if (s == 7'h48) return {1'b1, 4'hA};
    return 5'b0;
  endfunction

  function automatic void modelo_limpa();
    for (int i = 0; i < 4; i++) begin
      m_got[i] = 1'b0;
      m_val[i] = 4'h0;
    end
    m_err = 1'b0;
  endfunction

  // A legal pair held at least EST cycles fills its digit once; a blank run of TMO discards the frame
  function automatic void modelo(input logic [3:0] d, input logic [6:0] s, input int n);
    int k;
    logic [4:0] dec;
    quadro_t q;
    k = dig_idx(d);
    if (k < 0) begin
      m_blank += n;
      if (m_blank >= TMO) modelo_limpa();
    end else begin
      m_blank = 0;
      if (n >= EST && !m_got[k]) begin
        dec = decodifica(s);
        m_got[k] = 1'b1;
        m_val[k] = dec[3:0];
        if (!dec[4]) m_err = 1'b1;
        if (m_got[0] && m_got[1] && m_got[2] && m_got[3]) begin
          q.valor = {m_val[3], m_val[2], m_val[1], m_val[0]};
          q.erro  = m_err;
          fila.push_back(q);
          modelo_limpa();
        end
      end
    end
  endfunction

  task automatic esperar(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic seg(input logic [3:0] d, input logic [6:0] s, input int n);
    modelo(d, s, n);
    u_if.dig_n = d;
    u_if.seg_n = s;
    prev_d = d;
    prev_s = s;
    esperar(n);
  endtask

  task automatic varredura(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
    seg(4'b0111, s3, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1011, s2, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1101, s1, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1110, s0, 8); seg(4'hF, 7'h7F, 2);
  endtask

  task automatic reset_pulso(input int n);
    resetn = 1'b0;
    esperar(n);
    resetn = 1'b1;
    modelo_limpa();
    m_blank = 0;
  endtask

  // Monitor: every pulse must match the oldest frame the model produced
  initial begin
    quadro_t q;
    forever begin
      @(negedge clock);
      if (u_if.valido === 1'b1) begin
        chk("valido_consecutivo", {31'b0, prev_vld}, 32'd0);
        if (fila.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL valido_inesperado: got pulse with valor %0h, expected none", u_if.valor);
        end else begin
          q = fila.pop_front();
          chk("valor", {16'b0, u_if.valor}, {16'b0, q.valor});
          chk("erro",  {31'b0, u_if.erro},  {31'b0, q.erro});
        end
      end
      prev_vld = u_if.valido;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    logic [6:0] s;
    int g;
    int r;
    logic [3:0] multi [6] = '{4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b0110};

    u_if.dig_n = 4'hF;
    u_if.seg_n = 7'h7F;
    modelo_limpa();
    m_blank = 0;
    reset_pulso(3);
    chk("reset_valor",  {16'b0, u_if.valor},     32'd0);
    chk("reset_valido", {31'b0, u_if.valido},    32'd0);
    chk("reset_erro",   {31'b0, u_if.erro},      32'd0);
    chk("reset_sem",    {31'b0, u_if.sem_sinal}, 32'd0);

    // Basic scan 1234
    varredura(7'h79, 7'h24, 7'h30, 7'h19);

    // Glitch on digit 0: 00 too short, 12 stable
    seg(4'b0111, 7'h79, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1011, 7'h24, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1101, 7'h30, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1110, 7'h00, 2); seg(4'b1110, 7'h12, 8); seg(4'hF, 7'h7F, 2);

    // Invalid code on digit 2, alternate A on digit 1
    varredura(7'h79, 7'h7F, 7'h48, 7'h19);

    // Multiple selects are blank
    seg(4'b0011, 7'h24, 20);
    varredura(7'h02, 7'h78, 7'h00, 7'h10);

    // Timeout discards a partial frame
    seg(4'b0111, 7'h79, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1011, 7'h24, 8);
    u_if.dig_n = 4'hF; u_if.seg_n = 7'h7F;
    modelo(4'hF, 7'h7F, 101);
    esperar(101);
    chk("sem_antes_timeout", {31'b0, u_if.sem_sinal}, 32'd0);
    modelo(4'hF, 7'h7F, 1);
    esperar(1);
    chk("sem_no_timeout", {31'b0, u_if.sem_sinal}, 32'd1);
    seg(4'hF, 7'h7F, 5);
    chk("sem_mantido", {31'b0, u_if.sem_sinal}, 32'd1);
    modelo(4'b0111, 7'h46, 8);
    u_if.dig_n = 4'b0111; u_if.seg_n = 7'h46;
    esperar(2);
    chk("sem_antes_legal", {31'b0, u_if.sem_sinal}, 32'd1);
    esperar(1);
    chk("sem_apos_legal", {31'b0, u_if.sem_sinal}, 32'd0);
    esperar(5);
    seg(4'hF, 7'h7F, 2);
    seg(4'b1011, 7'h21, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1101, 7'h06, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1110, 7'h0E, 8); seg(4'hF, 7'h7F, 2);

    // Reset after three captures
    seg(4'b0111, 7'h03, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1011, 7'h12, 8); seg(4'hF, 7'h7F, 2);
    seg(4'b1101, 7'h40, 8); seg(4'hF, 7'h7F, 2);
    reset_pulso(1);
    chk("rst2_valor",  {16'b0, u_if.valor},     32'd0);
    chk("rst2_valido", {31'b0, u_if.valido},    32'd0);
    chk("rst2_erro",   {31'b0, u_if.erro},      32'd0);
    chk("rst2_sem",    {31'b0, u_if.sem_sinal}, 32'd0);
    seg(4'b1110, 7'h19, 8); seg(4'hF, 7'h7F, 6);
    chk("sem_quadro_parcial", fila.size(), 32'd0);
    varredura(7'h08, 7'h03, 7'h46, 7'h21);

    // Randomized segments: short holds, invalid codes, multi-selects, back-to-back pairs
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) d = multi[$urandom_range(0, 5)];
      else d = ~(4'(4'b0001 << $urandom_range(0, 3)));
      r = $urandom_range(0, 16);
      if ($urandom_range(0, 9) < 2) s = 7'($urandom);
      else if (r == 16) s = 7'h48;
      else s = fonte[r];
      g = $urandom_range(0, 2);
      if (g == 0 && d == prev_d && s == prev_s) g = 1;
      if (g > 0) seg(4'hF, 7'h7F, g);
      seg(d, s, $urandom_range(1, 10));
    end
    seg(4'hF, 7'h7F, 20);

    chk("fila_restante", fila.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
